rr_arb2_sel: RTL and testbench
==============================

# rr_arb2_sel

Two-input round-robin stream arbiter with a registered output stage. It sits directly upstream of the team's 2:1 mux (`mux2to1`): it decides which of two valid/ready sources owns each output beat and drives the mux select (`sel`: 0 = input `a`, 1 = input `b`). It also captures the winning data word into a one-entry output register, so the downstream consumer sees a registered stream with backpressure.

## Interface
- `DW`, default 8, width of the data words.

- `clk`  input  1  rising-edge clock, the only clock.
- `rst`  input  1  synchronous, active-high reset.
- `a_valid`  input  1  source A has a word.
- `a_data`  input  DW  source A word.
- `a_ready`  output  1  A word is taken this cycle.
- `b_valid`  input  1  source B has a word.
- `b_data`  input  DW  source B word.
- `b_ready`  output  1  B word is taken this cycle.
- `out_valid`  output  1  output register holds a word.
- `out_data`  output  DW  registered winning word.
- `out_ready`  input  1  consumer accepts the output word.
- `sel`  output  1  source of the current `out_data` (0 = A, 1 = B); drives the 2:1 mux select.

## Operation
- Transfer rule: a transfer happens on any channel when valid && ready is true at a rising edge.
- Load condition: `load = !out_valid || out_ready`. The output register is empty, or it is draining this cycle.
- Priority flag `prio_b`, internal, reset 0 (A preferred).
- Winner selection (combinational):
  - only A valid -> A;
  - only B valid -> B;
  - both valid -> B if `prio_b`, else A;
  - neither -> none.
- Ready outputs: `a_ready = load && winner==A`; `b_ready = load && winner==B`. They are never both 1. A ready never depends on the other source's ready.
- On an edge with `load` and a winner:
  - `out_data` <= winner data;
  - `out_valid` <= 1;
  - `sel` <= winner;
  - `prio_b` <= (winner==A).
- On an edge with `load` and no winner: `out_valid` <= 0; `out_data`, `sel` and `prio_b` hold.
- With `!load` (output stalled): all state holds, both readies are 0, and sources must keep their words.
- Fairness: under continuous requests from both sources, grants alternate A, B, A, B... A lone requester is granted every cycle, and each grant still updates `prio_b`.

## Timing
- Reset values: `out_valid`=0, `out_data`=0, `sel`=0, `prio_b`=0. `a_ready` and `b_ready` are 0 while `rst` is high.
- Latency: an input word accepted at edge N appears on `out_data` with `out_valid`=1 immediately after edge N.
- Throughput: one word per cycle when `out_ready` is held at 1.
- Simultaneous drain and load: when `out_valid && out_ready` and a winner exists in the same cycle, the old word leaves and the new word loads on the same edge, with no bubble.
- Stall: `out_data` and `sel` are stable for as long as `out_valid && !out_ready`.
- Reset mid-operation: `rst` high at an edge discards any held word, forces the reset values, and ignores valids in that cycle.

## Test plan
- Reset: `rst`=1 for 2 cycles with both valids high. Required: `out_valid`=0, `sel`=0, `out_data`=0, both readies 0. On the first cycle after release with both valid, A is granted.
- Alternation: `a_data`=8'hA1, `b_data`=8'hB2, both valid, `out_ready`=1 for 6 cycles. Required: `out_data` sequence A1,B2,A1,B2,A1,B2 and `sel` sequence 0,1,0,1,0,1.
- Single source: only B valid with `b_data`=8'h3C for 3 cycles. Required: `b_ready`=1 every cycle, `out_data`=3C, `sel`=1. After that, both valid -> A is granted next (`prio_b` was cleared by the B grants).
- Backpressure: load 8'h55 from A, then hold `out_ready`=0 for 4 cycles with both valid. Required: `out_data`=55, `sel`=0, both readies 0 throughout. Releasing `out_ready` then loads B on the same edge the 55 drains.
- Empty gap: `out_valid`=1 and `out_ready`=1 with no valids. Required: `out_valid` falls to 0 after the edge, and `out_data` and `sel` hold their last values.
- Reset mid-stall: a word is held with `out_ready`=0, then `rst` pulses for 1 cycle. Required: `out_valid`=0 and `sel`=0 after the edge, and A wins the next contested cycle.

Source files
------------

// File: rtl/rr_arb2_sel.sv
// rr_arb2_sel: two-input round-robin stream arbiter with a registered output stage and mux select
module rr_arb2_sel #(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          a_valid,
  input  logic [DW-1:0] a_data,
  output logic          a_ready,
  input  logic          b_valid,
  input  logic [DW-1:0] b_data,
  output logic          b_ready,
  output logic          out_valid,
  output logic [DW-1:0] out_data,
  input  logic          out_ready,
  output logic          sel
);
  logic prio_b, load, win_a, win_b;
  assign load    = !out_valid || out_ready;
  assign win_b   = b_valid && (!a_valid || prio_b);
  assign win_a   = a_valid && !win_b;
  assign a_ready = !rst && load && win_a;
  assign b_ready = !rst && load && win_b;
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      sel       <= 1'b0;
      prio_b    <= 1'b0;
    end else if (load) begin
      out_valid <= win_a || win_b;
      if (win_a || win_b) begin
        out_data <= win_b ? b_data : a_data;
        sel      <= win_b;
        prio_b   <= win_a;
      end
    end
  end
endmodule

// File: tb/tb_rr_arb2_sel.sv
// tb_rr_arb2_sel: scoreboard bench for the round-robin arbiter with registered output
module tb_rr_arb2_sel;
  localparam int DW = 8;
  logic clk = 1'b0, rst = 1'b1;
  logic a_valid = 1'b0, b_valid = 1'b0, out_ready = 1'b0;
  logic [DW-1:0] a_data = '0, b_data = '0;
  logic a_ready, b_ready, out_valid, sel;
  logic [DW-1:0] out_data;
  int n_cmp = 0, n_err = 0;
  logic m_ov = 1'b0, m_sel = 1'b0, m_prio = 1'b0;
  logic [DW-1:0] m_data = '0;
  logic [DW:0] sb[$];

  rr_arb2_sel #(.DW(DW)) dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_data(a_data), .a_ready(a_ready),
    .b_valid(b_valid), .b_data(b_data), .b_ready(b_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .sel(sel)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic rst_cycle(input logic av, input logic bv);
    @(negedge clk);
    rst = 1'b1; a_valid = av; b_valid = bv; out_ready = 1'b1;
    #1;
    chk("rst_a_ready", a_ready, 0);
    chk("rst_b_ready", b_ready, 0);
    @(posedge clk); #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_sel", sel, 0);
    m_ov = 0; m_sel = 0; m_prio = 0; m_data = '0;
    sb.delete();
  endtask

  task automatic step(input logic av, input logic [DW-1:0] ad, input logic bv,
                      input logic [DW-1:0] bd, input logic ordy);
    logic mload, mwa, mwb;
    logic [DW:0] e;
    @(negedge clk);
    rst = 1'b0; a_valid = av; a_data = ad; b_valid = bv; b_data = bd; out_ready = ordy;
    #1;
    mload = !m_ov || ordy;
    mwb = bv && (!av || m_prio);
    mwa = av && !mwb;
    chk("a_ready", a_ready, mload && mwa);
    chk("b_ready", b_ready, mload && mwb);
    if (m_ov && ordy) begin
      if (sb.size() == 0) chk("sb_empty", 1, 0);
      else begin
        e = sb.pop_front();
        chk("drain_data", out_data, e[DW-1:0]);
        chk("drain_sel", sel, e[DW]);
      end
    end
    if (mload && (mwa || mwb)) begin
      m_data = mwb ? bd : ad;
      m_sel = mwb; m_prio = mwa; m_ov = 1;
      sb.push_back({m_sel, m_data});
    end else if (mload) m_ov = 0;
    @(posedge clk); #1;
    chk("out_valid", out_valid, m_ov);
    chk("out_data", out_data, m_data);
    chk("sel", sel, m_sel);
  endtask

  initial begin
    logic [DW-1:0] alt_d [6];
    a_data = 8'hA1; b_data = 8'hB2;
    rst_cycle(1, 1);
    rst_cycle(1, 1);
    alt_d = '{8'hA1, 8'hB2, 8'hA1, 8'hB2, 8'hA1, 8'hB2};
    for (int i = 0; i < 6; i++) begin
      step(1, 8'hA1, 1, 8'hB2, 1);
      chk("alt_data", out_data, alt_d[i]);
      chk("alt_sel", sel, i % 2);
    end
    for (int i = 0; i < 3; i++) begin
      step(0, 8'h00, 1, 8'h3C, 1);
      chk("solo_b_data", out_data, 8'h3C);
      chk("solo_b_sel", sel, 1);
    end
    step(1, 8'h11, 1, 8'h22, 1);
    chk("after_solo_a", out_data, 8'h11);
    step(1, 8'h55, 0, 8'h00, 1);
    chk("bp_load", out_data, 8'h55);
    for (int i = 0; i < 4; i++) begin
      step(1, 8'h66, 1, 8'h77, 0);
      chk("bp_hold_data", out_data, 8'h55);
      chk("bp_hold_sel", sel, 0);
    end
    step(1, 8'h66, 1, 8'h77, 1);
    chk("bp_release_b", out_data, 8'h77);
    chk("bp_release_sel", sel, 1);
    step(0, 8'h00, 0, 8'h00, 1);
    chk("gap_valid", out_valid, 0);
    chk("gap_data", out_data, 8'h77);
    chk("gap_sel", sel, 1);
    step(0, 8'h00, 1, 8'h99, 1);
    step(1, 8'h44, 1, 8'h88, 0);
    rst_cycle(1, 1);
    step(1, 8'hAA, 1, 8'hBB, 1);
    chk("post_rst_a", out_data, 8'hAA);
    for (int i = 0; i < 60; i++)
      step(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)),
           8'($urandom), 1'($urandom_range(0, 3) != 0));
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end
endmodule
